// File: rtl/stopwatch_core.sv
// stopwatch_core: centisecond stopwatch counting MM:SS.CC in packed BCD.
// Everything runs on clk_50mhz; clk100hz is only edge-detected to form a
// one-cycle count tick.
// Optional build macro: STOPWATCH_LAP_EN adds the lap/lap_active ports and
// a frozen lap display; without it the outputs always show the live count.
//
// state | meaning
// IDLE  | cleared, not counting
// RUN   | counting on every tick
// PAUSE | holding the count, resumes on start_stop
module stopwatch_core #(
  parameter int MIN_LIMIT = 59,
  parameter int WRAP      = 1
) (
  input  logic       clk_50mhz,
  input  logic       rst_n,
  input  logic       clk100hz,
  input  logic       start_stop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
  output logic       lap_active,
`endif
  output logic [7:0] cs_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic       running,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [3:0] MIN_T = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] MIN_O = 4'(MIN_LIMIT % 10);

  state_t     state;
  logic       clk100hz_q;
  logic       tick;
  logic       at_max;
  logic [3:0] cs_t, cs_o, sec_t, sec_o, min_t, min_o;

  assign tick    = clk100hz & ~clk100hz_q;
  assign at_max  = ({min_t, min_o} == {MIN_T, MIN_O}) &&
                   ({sec_t, sec_o} == 8'h59) && ({cs_t, cs_o} == 8'h99);
  assign running = (state == RUN);

  // delay the 100 Hz square wave by one cycle for rising-edge detection
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) clk100hz_q <= 1'b0;
    else        clk100hz_q <= clk100hz;
  end

  // run/pause FSM with the BCD carry chain; counting uses the pre-transition state
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      overflow <= 1'b0;
      cs_t     <= 4'd0;
      cs_o     <= 4'd0;
      sec_t    <= 4'd0;
      sec_o    <= 4'd0;
      min_t    <= 4'd0;
      min_o    <= 4'd0;
    end else if (clear) begin
      state    <= IDLE;
      overflow <= 1'b0;
      cs_t     <= 4'd0;
      cs_o     <= 4'd0;
      sec_t    <= 4'd0;
      sec_o    <= 4'd0;
      min_t    <= 4'd0;
      min_o    <= 4'd0;
    end else begin
      if (tick && state == RUN) begin
        if (at_max) begin
          overflow <= 1'b1;
          // saturating builds simply hold the maximum
          if (WRAP != 0) begin
            cs_t  <= 4'd0;
            cs_o  <= 4'd0;
            sec_t <= 4'd0;
            sec_o <= 4'd0;
            min_t <= 4'd0;
            min_o <= 4'd0;
          end
        end else if (cs_o != 4'd9) begin
          cs_o <= cs_o + 4'd1;
        end else begin
          cs_o <= 4'd0;
          if (cs_t != 4'd9) begin
            cs_t <= cs_t + 4'd1;
          end else begin
            cs_t <= 4'd0;
            if (sec_o != 4'd9) begin
              sec_o <= sec_o + 4'd1;
            end else begin
              sec_o <= 4'd0;
              if (sec_t != 4'd5) begin
                sec_t <= sec_t + 4'd1;
              end else begin
                sec_t <= 4'd0;
                if (min_o != 4'd9) begin
                  min_o <= min_o + 4'd1;
                end else begin
                  min_o <= 4'd0;
                  min_t <= min_t + 4'd1;
                end
              end
            end
          end
        end
      end

      case (state)
        IDLE:    if (start_stop) state <= RUN;
        RUN:     if (start_stop || (tick && at_max && WRAP == 0)) state <= PAUSE;
        PAUSE:   if (start_stop) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [7:0] snap_cs, snap_sec, snap_min;

  // lap hold: toggled only while running, snapshot taken from the pre-edge count
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      lap_active <= 1'b0;
      snap_cs    <= 8'h00;
      snap_sec   <= 8'h00;
      snap_min   <= 8'h00;
    end else if (clear) begin
      lap_active <= 1'b0;
    end else if (lap && state == RUN) begin
      if (lap_active) begin
        lap_active <= 1'b0;
      end else begin
        lap_active <= 1'b1;
        snap_cs    <= {cs_t, cs_o};
        snap_sec   <= {sec_t, sec_o};
        snap_min   <= {min_t, min_o};
      end
    end
  end

  assign cs_bcd  = lap_active ? snap_cs  : {cs_t, cs_o};
  assign sec_bcd = lap_active ? snap_sec : {sec_t, sec_o};
  assign min_bcd = lap_active ? snap_min : {min_t, min_o};
`else
  assign cs_bcd  = {cs_t, cs_o};
  assign sec_bcd = {sec_t, sec_o};
  assign min_bcd = {min_t, min_o};
`endif

endmodule
